// File: rtl/imem_byte_writer_if.sv
// imem_byte_writer_if: loader-side word stream, session status and byte-wide memory write port
interface imem_byte_writer_if #(
   parameter int INSTRUCTION_SIZE = 32
);
   logic                        Start;
   logic [31:0]                 BaseAddress;
   logic [15:0]                 WordCount;
   logic [INSTRUCTION_SIZE-1:0] WordData;
   logic                        WordValid;
   logic                        WordReady;
   logic                        MemWriteEnable;
   logic [31:0]                 MemWriteAddress;
   logic [7:0]                  MemWriteData;
   logic                        Busy;
   logic                        Done;
   logic                        Error;
   logic                        CpuHold;
   logic [INSTRUCTION_SIZE-1:0] Checksum;

   // master: the program loader and the memory observer
   modport master (
      output Start, BaseAddress, WordCount, WordData, WordValid,
      input  WordReady, MemWriteEnable, MemWriteAddress, MemWriteData,
      input  Busy, Done, Error, CpuHold, Checksum
   );

   // slave: the byte writer itself
   modport slave (
      input  Start, BaseAddress, WordCount, WordData, WordValid,
      output WordReady, MemWriteEnable, MemWriteAddress, MemWriteData,
      output Busy, Done, Error, CpuHold, Checksum
   );
endinterface

// File: rtl/imem_byte_writer.sv
// imem_byte_writer: commits streamed 32-bit words as four little-endian byte writes, holding the core in reset until the load completes
module imem_byte_writer #(
   parameter int INSTRUCTION_SIZE = 32,
   parameter int MEM_SIZE         = 1024
) (
   input logic                clk,
   input logic                rst_n,
   imem_byte_writer_if.slave  bus
);
   typedef enum logic [2:0] {IDLE, WAIT_WORD, WRITE, DONE, ERR} state_t;

   state_t                      r_state;
   logic [31:0]                 r_addr;
   logic [15:0]                 r_rem;
   logic [INSTRUCTION_SIZE-1:0] r_word;
   logic [1:0]                  r_idx;
   logic                        r_ready;
   logic                        r_we;
   logic [31:0]                 r_waddr;
   logic [7:0]                  r_wdata;
   logic                        r_busy;
   logic                        r_done;
   logic                        r_error;
   logic                        r_hold;
   logic [INSTRUCTION_SIZE-1:0] r_sum;

   logic [33:0] w_end;
   logic        w_oob;
   logic        w_take;
   logic        w_last_word;
   logic [1:0]  w_idx_nxt;
   logic [7:0]  w_byte;

   // End of session computed in 34 bits so a high base plus a large count cannot wrap past the bound
   assign w_end       = {2'b00, bus.BaseAddress[31:2], 2'b00} + {16'b0, bus.WordCount, 2'b00};
   assign w_oob       = w_end > 34'(MEM_SIZE);
   assign w_take      = bus.WordValid && r_ready;
   assign w_last_word = r_rem == 16'd1;
   assign w_idx_nxt   = r_idx + 2'd1;
   assign w_byte      = 8'(r_word >> {w_idx_nxt, 3'b000});

   // Session FSM; every output is a register so the memory port sees clean, glitch-free strobes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_addr  <= '0;
         r_rem   <= '0;
         r_word  <= '0;
         r_idx   <= '0;
         r_ready <= 1'b0;
         r_we    <= 1'b0;
         r_waddr <= '0;
         r_wdata <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_error <= 1'b0;
         r_hold  <= 1'b1;
         r_sum   <= '0;
      end else begin
         r_we    <= 1'b0;
         r_waddr <= '0;
         r_wdata <= '0;
         r_done  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.Start) begin
                  r_error <= 1'b0;
                  r_sum   <= '0;
                  r_hold  <= 1'b1;
                  r_addr  <= {bus.BaseAddress[31:2], 2'b00};
                  r_rem   <= bus.WordCount;
                  if (bus.WordCount == 16'd0) begin
                     r_state <= DONE;
                     r_done  <= 1'b1;
                     r_hold  <= 1'b0;
                     r_busy  <= 1'b1;
                  end else if (w_oob) begin
                     r_state <= ERR;
                     r_error <= 1'b1;
                  end else begin
                     r_state <= WAIT_WORD;
                     r_ready <= 1'b1;
                     r_busy  <= 1'b1;
                  end
               end
            end
            WAIT_WORD: begin
               if (w_take) begin
                  r_word  <= bus.WordData;
                  r_sum   <= r_sum + bus.WordData;
                  r_idx   <= 2'd0;
                  r_ready <= 1'b0;
                  r_we    <= 1'b1;
                  r_waddr <= r_addr;
                  r_wdata <= bus.WordData[7:0];
                  r_state <= WRITE;
               end
            end
            WRITE: begin
               if (r_idx == 2'd3) begin
                  r_addr <= r_addr + 32'd4;
                  r_rem  <= r_rem - 16'd1;
                  if (w_last_word) begin
                     r_state <= DONE;
                     r_done  <= 1'b1;
                     r_hold  <= 1'b0;
                  end else begin
                     r_state <= WAIT_WORD;
                     r_ready <= 1'b1;
                  end
               end else begin
                  r_idx   <= w_idx_nxt;
                  r_we    <= 1'b1;
                  r_waddr <= r_addr + {30'b0, w_idx_nxt};
                  r_wdata <= w_byte;
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
            ERR: r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.WordReady       = r_ready;
   assign bus.MemWriteEnable  = r_we;
   assign bus.MemWriteAddress = r_waddr;
   assign bus.MemWriteData    = r_wdata;
   assign bus.Busy            = r_busy;
   assign bus.Done            = r_done;
   assign bus.Error           = r_error;
   assign bus.CpuHold         = r_hold;
   assign bus.Checksum        = r_sum;
endmodule
